regfile_cmd_sequencer: RTL and testbench
========================================

Name: regfile_cmd_sequencer

Overview:
Command sequencer for the 32x16 register file and its LCD readout. Collects a 3-bit command plus a stream of 4-bit tokens (one per rotary event) over a valid/ready handshake. Drives the register-file read and write ports and computes the ALU result (signed compare, XOR, arithmetic shift). Hands the two display values to the LCD formatter with a start/end handshake.

Parameters:
TIMEOUT_CYC, 50000000, idle cycles allowed between tokens before the command is abandoned (used only with SEQ_TIMEOUT_EN).

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd  in  3  opcode 0..7
cmd_ready  out  1  high only in IDLE
tok_valid  in  1  token present (one per rotary event)
tok  in  4  token nibble
tok_ready  out  1  high only in COLLECT
rf_raddr1  out  5  read address A
rf_raddr2  out  5  read address B
rf_rdata1  in  16  combinational read data at rf_raddr1
rf_rdata2  in  16  combinational read data at rf_raddr2
rf_we  out  1  write strobe, one cycle
rf_waddr  out  5  write address W
rf_wdata  out  16  write data
disp_start  out  1  display request (level)
disp_end  in  1  display complete (pulse)
disp_hi  out  16  first LCD line value
disp_lo  out  16  second LCD line value
disp_hi_is_addr  out  1  disp_hi holds a 5-bit address, zero-extended
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a command completes
err  out  1  one-cycle pulse when a command times out (SEQ_TIMEOUT_EN only; else tied 0)

Behaviour:
- Reset: asynchronous, active-low. Forces state IDLE and clears every output register, address, data and token counter to 0. A pending write or display request is dropped.
- States: IDLE, COLLECT, EXEC, WRITE, SHOW, WAIT_DISP.
- IDLE: on cmd_valid, latch cmd, clear the token counter, go to COLLECT.
- COLLECT: each accepted token (tok_valid and tok_ready) fills the next field in order.
  - An address takes 2 tokens: the first gives addr[4:1]; the second gives addr[0] from tok[0], with tok[3:1] ignored.
  - Data takes 4 tokens, MS nibble first.
  - The shift amount takes 1 token.
- Token sequence per cmd:
  - 0: W, D. Write D to W; display W / D.
  - 1: A. Display A / rdata1.
  - 2: A, B. Display rdata1 / rdata2.
  - 3: A, W, D. Write D to W; display A / rdata1.
  - 4: A, B, W, D. Write D to W; display rdata1 / rdata2.
  - 5: A, B, W. Write {15'b0, signed(rdata1) < signed(rdata2)} to W; display W / result.
  - 6: A, B, W. Write rdata1 ^ rdata2 to W; display W / result.
  - 7: A, W, S. Write signed(rdata1) >>> S (S = 0..15, sign-filled) to W; display W / result.
- After the last token: go to EXEC. Commands 1 and 2 skip EXEC and WRITE and go straight to SHOW.
- EXEC (1 cycle): register the result from the rdata values presented in that cycle.
- WRITE (1 cycle): rf_we=1 with rf_waddr/rf_wdata valid.
- SHOW (1 cycle): load disp_hi, disp_lo and disp_hi_is_addr; set disp_start=1.
  - rdata is sampled in SHOW, after the write edge, so cmd 3/4 with W==A or W==B display the newly written value.
- WAIT_DISP: hold disp_start and the display values. On disp_end: disp_start=0, done=1 for one cycle, go to IDLE.
  - A disp_end arriving in the same cycle as SHOW is ignored.
- Latency: last token accepted to rf_we = 2 cycles; to disp_start = 3 cycles (cmd 1/2: 1 cycle).
- rf_raddr1/2 hold their last value between commands. rf_we is never asserted outside WRITE.
- cmd_valid while busy is ignored (cmd_ready=0). tok_valid outside COLLECT is ignored (no token consumed).

Optional Feature:
SEQ_TIMEOUT_EN.
- Defined: a counter runs in COLLECT and reloads on every accepted token. When TIMEOUT_CYC cycles pass with no token: err=1 for one cycle, return to IDLE, no register write, no display request.
- Undefined: no counter is built, COLLECT waits indefinitely, and err is tied 0.

Test Plan:
- cmd0, tokens 0x3,1,0xA,0xB,0xC,0xD → rf_we one cycle with waddr=7, wdata=0xABCD; disp_hi=7, disp_hi_is_addr=1, disp_lo=0xABCD; done after disp_end.
- Preload R1=0x8000, R2=0x0001; cmd7 with A=1, W=3, S=4 → R3=0xF800. Then cmd5 with A=1, B=2, W=4 → R4=0x0001, disp_lo=0x0001.
- cmd4 with A=5, B=6, W=5, D=0x1234 → the display shows disp_hi=0x1234 (post-write value).
- Pulse rst_n low after 3 tokens of cmd0 → all outputs 0 immediately (asynchronous), no rf_we; next cmd_valid accepted normally.
- Hold cmd_valid and tok_valid during WAIT_DISP → no token consumed and cmd not re-latched; disp_start stays 1 until disp_end.
- With SEQ_TIMEOUT_EN and TIMEOUT_CYC=8: cmd1, one token, then idle 8 cycles → err pulse, state IDLE, disp_start never asserted.

Source files
------------

// File: rtl/regfile_cmd_sequencer.sv
// Command sequencer for the 32x16 register file and its LCD readout: token collection, ALU, write and display handshake.
// Optional build macro SEQ_TIMEOUT_EN abandons a command after TIMEOUT_CYC idle cycles in COLLECT.
//
// state       | meaning
// ------------+--------------------------------------------------------
// IDLE        | waiting for cmd_valid
// COLLECT     | accepting tokens into A, B, W, D, S fields
// EXEC        | result registered from rdata (cmd 0,3-7)
// WRITE       | rf_we pulse with rf_waddr / rf_wdata
// SHOW        | display values loaded, disp_start raised
// WAIT_DISP   | holding display request until disp_end
module regfile_cmd_sequencer #(
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd,
    output logic        cmd_ready,
    input  logic        tok_valid,
    input  logic [3:0]  tok,
    output logic        tok_ready,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [15:0] rf_rdata1,
    input  logic [15:0] rf_rdata2,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic        disp_start,
    input  logic        disp_end,
    output logic [15:0] disp_hi,
    output logic [15:0] disp_lo,
    output logic        disp_hi_is_addr,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_EXEC, S_WRITE, S_SHOW, S_WAIT_DISP
    } state_t;

    typedef enum logic [2:0] {F_A, F_B, F_W, F_D, F_S} field_t;

    state_t      state, state_nxt;
    logic [2:0]  cmd_q;
    logic [3:0]  tok_cnt;
    logic [15:0] data_q;
    logic [3:0]  shamt;
    logic        tok_acc;
    logic        tok_last;
    logic        has_a, has_b, has_w, has_d, has_s;
    logic [3:0]  b_off, w_off, d_off, tok_total;
    field_t      fld;
    logic [1:0]  sub;
    logic        tmo_fire;

    assign tok_acc = (state == S_COLLECT) && tok_valid;

    always_comb begin
        has_a = 1'b0;
        has_b = 1'b0;
        has_w = 1'b0;
        has_d = 1'b0;
        has_s = 1'b0;
        case (cmd_q)
            3'd0: begin has_w = 1'b1; has_d = 1'b1; end
            3'd1: has_a = 1'b1;
            3'd2: begin has_a = 1'b1; has_b = 1'b1; end
            3'd3: begin has_a = 1'b1; has_w = 1'b1; has_d = 1'b1; end
            3'd4: begin has_a = 1'b1; has_b = 1'b1; has_w = 1'b1; has_d = 1'b1; end
            3'd5, 3'd6: begin has_a = 1'b1; has_b = 1'b1; has_w = 1'b1; end
            default: begin has_a = 1'b1; has_w = 1'b1; has_s = 1'b1; end
        endcase
    end

    // Field offsets collapse to the previous one when a field is absent.
    assign b_off     = has_a ? 4'd2 : 4'd0;
    assign w_off     = b_off + (has_b ? 4'd2 : 4'd0);
    assign d_off     = w_off + (has_w ? 4'd2 : 4'd0);
    assign tok_total = d_off + (has_d ? 4'd4 : 4'd0) + (has_s ? 4'd1 : 4'd0);
    assign tok_last  = (tok_cnt == tok_total - 4'd1);

    always_comb begin
        fld = F_S;
        sub = 2'd0;
        if (tok_cnt < b_off) begin
            fld = F_A;
            sub = tok_cnt[1:0];
        end else if (tok_cnt < w_off) begin
            fld = F_B;
            sub = 2'(tok_cnt - b_off);
        end else if (tok_cnt < d_off) begin
            fld = F_W;
            sub = 2'(tok_cnt - w_off);
        end else if (has_d) begin
            fld = F_D;
            sub = 2'(tok_cnt - d_off);
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;

    assign tmo_fire = (state == S_COLLECT) && !tok_valid && (tmo_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= tmo_fire;
            if (state != S_COLLECT || tok_acc) begin
                tmo_cnt <= TMO_W'(TIMEOUT_CYC - 1);
            end else if (tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign tmo_fire = 1'b0;
    assign err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (cmd_valid) state_nxt = S_COLLECT;
            S_COLLECT: begin
                if (tok_acc && tok_last) begin
                    state_nxt = (cmd_q == 3'd1 || cmd_q == 3'd2) ? S_SHOW : S_EXEC;
                end else if (tmo_fire) begin
                    state_nxt = S_IDLE;
                end
            end
            S_EXEC:      state_nxt = S_WRITE;
            S_WRITE:     state_nxt = S_SHOW;
            S_SHOW:      state_nxt = S_WAIT_DISP;
            S_WAIT_DISP: if (disp_end) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    assign cmd_ready = (state == S_IDLE);
    assign tok_ready = (state == S_COLLECT);
    assign busy      = (state != S_IDLE);
    assign rf_we     = (state == S_WRITE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q           <= 3'd0;
            tok_cnt         <= 4'd0;
            rf_raddr1       <= 5'd0;
            rf_raddr2       <= 5'd0;
            rf_waddr        <= 5'd0;
            data_q          <= 16'd0;
            shamt           <= 4'd0;
            rf_wdata        <= 16'd0;
            disp_hi         <= 16'd0;
            disp_lo         <= 16'd0;
            disp_hi_is_addr <= 1'b0;
            disp_start      <= 1'b0;
            done            <= 1'b0;
        end else begin
            disp_start <= (state_nxt == S_SHOW) || (state_nxt == S_WAIT_DISP);
            done       <= (state == S_WAIT_DISP) && disp_end;

            if (state == S_IDLE && cmd_valid) begin
                cmd_q   <= cmd;
                tok_cnt <= 4'd0;
            end

            if (tok_acc) begin
                tok_cnt <= tok_cnt + 4'd1;
                case (fld)
                    F_A: if (sub[0]) rf_raddr1[0] <= tok[0]; else rf_raddr1[4:1] <= tok;
                    F_B: if (sub[0]) rf_raddr2[0] <= tok[0]; else rf_raddr2[4:1] <= tok;
                    F_W: if (sub[0]) rf_waddr[0]  <= tok[0]; else rf_waddr[4:1]  <= tok;
                    F_D: begin
                        case (sub)
                            2'd0:    data_q[15:12] <= tok;
                            2'd1:    data_q[11:8]  <= tok;
                            2'd2:    data_q[7:4]   <= tok;
                            default: data_q[3:0]   <= tok;
                        endcase
                    end
                    default: shamt <= tok;
                endcase
            end

            if (state == S_EXEC) begin
                case (cmd_q)
                    3'd5:    rf_wdata <= {15'd0, ($signed(rf_rdata1) < $signed(rf_rdata2))};
                    3'd6:    rf_wdata <= rf_rdata1 ^ rf_rdata2;
                    3'd7:    rf_wdata <= 16'($signed(rf_rdata1) >>> shamt);
                    default: rf_wdata <= data_q;
                endcase
            end

            // rdata sampled here already reflects the write committed at the end of WRITE.
            if (state == S_SHOW) begin
                case (cmd_q)
                    3'd0: begin
                        disp_hi         <= {11'd0, rf_waddr};
                        disp_lo         <= data_q;
                        disp_hi_is_addr <= 1'b1;
                    end
                    3'd1, 3'd3: begin
                        disp_hi         <= {11'd0, rf_raddr1};
                        disp_lo         <= rf_rdata1;
                        disp_hi_is_addr <= 1'b1;
                    end
                    3'd2, 3'd4: begin
                        disp_hi         <= rf_rdata1;
                        disp_lo         <= rf_rdata2;
                        disp_hi_is_addr <= 1'b0;
                    end
                    default: begin
                        disp_hi         <= {11'd0, rf_waddr};
                        disp_lo         <= rf_wdata;
                        disp_hi_is_addr <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_regfile_cmd_sequencer.sv
// Scoreboard bench for regfile_cmd_sequencer: directed commands push expected writes/displays, a monitor checks them.
module tb_regfile_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, tok_valid, disp_end;
    logic [2:0]  cmd;
    logic [3:0]  tok;
    logic        cmd_ready, tok_ready, rf_we, disp_start, disp_hi_is_addr, busy, done, err;
    logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr;
    logic [15:0] rf_rdata1, rf_rdata2, rf_wdata, disp_hi, disp_lo;

    logic [15:0] rf_mem [32];

    typedef struct {
        logic [4:0]  a;
        logic [15:0] d;
    } wr_t;

    typedef struct {
        logic [15:0] hi;
        logic [15:0] lo;
        logic        ia;
        int          lat;
    } disp_t;

    wr_t   exp_wr[$];
    disp_t exp_disp[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_tok = 0;
    int n_rise   = 0;
    int n_err    = 0;
    int disp_delay = 3;
    logic early_end = 1'b0;

    regfile_cmd_sequencer #(.TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
        .tok_valid(tok_valid), .tok(tok), .tok_ready(tok_ready),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .disp_start(disp_start), .disp_end(disp_end),
        .disp_hi(disp_hi), .disp_lo(disp_lo), .disp_hi_is_addr(disp_hi_is_addr),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    assign rf_rdata1 = rf_mem[rf_raddr1];
    assign rf_rdata2 = rf_mem[rf_raddr2];

    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_wr(input logic [4:0] a, input logic [15:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_wr.push_back(w);
    endtask

    task automatic push_disp(input logic [15:0] hi, input logic [15:0] lo, input logic ia, input int lat);
        disp_t e;
        e.hi = hi;
        e.lo = lo;
        e.ia = ia;
        e.lat = lat;
        exp_disp.push_back(e);
    endtask

    // Display responder: optional bogus pulse during SHOW, then a real pulse disp_delay cycles later.
    initial begin
        disp_end = 1'b0;
        forever begin
            @(posedge disp_start);
            if (early_end) begin
                #1 disp_end = 1'b1;
                @(posedge clk);
                #1 disp_end = 1'b0;
            end
            repeat (disp_delay) @(posedge clk);
            #1 disp_end = 1'b1;
            @(posedge clk);
            #1 disp_end = 1'b0;
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic ds_q;
        wr_t w;
        disp_t e;
        ds_q = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                ds_q = 1'b0;
            end else begin
                if (tok_valid && tok_ready) last_tok = cyc;
                if (err) n_err++;
                if (rf_we) begin
                    chk("write_expected", exp_wr.size() != 0, 1);
                    if (exp_wr.size() != 0) begin
                        w = exp_wr.pop_front();
                        chk("rf_waddr", rf_waddr, w.a);
                        chk("rf_wdata", rf_wdata, w.d);
                        chk("we_latency", cyc - last_tok, 2);
                    end
                end
                if (disp_start && !ds_q) begin
                    n_rise++;
                    chk("disp_expected", exp_disp.size() != 0, 1);
                    if (exp_disp.size() != 0) chk("disp_latency", cyc - last_tok, exp_disp[0].lat);
                end
                if (done) begin
                    chk("done_expected", exp_disp.size() != 0, 1);
                    if (exp_disp.size() != 0) begin
                        e = exp_disp.pop_front();
                        chk("disp_hi", disp_hi, e.hi);
                        chk("disp_lo", disp_lo, e.lo);
                        chk("disp_hi_is_addr", disp_hi_is_addr, e.ia);
                    end
                end
                ds_q = disp_start;
            end
        end
    end

    // Tokens are packed first-token-most-significant: 40'h31ABCD with n=6 sends 3,1,A,B,C,D.
    task automatic send_tok(input int n, input logic [39:0] toks);
        for (int i = 0; i < n; i++) begin
            tok = toks[4*(n-1-i) +: 4];
            tok_valid = 1'b1;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (tok_ready) break;
            end
            chk("tok_accept", tok_ready, 1);
            @(posedge clk);
            #1 tok_valid = 1'b0;
        end
    endtask

    task automatic send_cmd(input logic [2:0] c, input int n, input logic [39:0] toks);
        cmd = c;
        cmd_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        chk("cmd_accept", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        send_tok(n, toks);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done_seen", done, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rise0;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd = 3'd0;
        tok_valid = 1'b0;
        tok = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", {busy, tok_ready, rf_we, disp_start, done, err, disp_hi_is_addr,
                        rf_raddr1, rf_raddr2, rf_waddr}, 0);
        chk("rst_data", {rf_wdata, disp_hi}, 0);
        chk("rst_lo", disp_lo, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_ready", {cmd_ready, busy}, 2'b10);

        // cmd0: W=7, D=ABCD
        push_wr(5'd7, 16'hABCD);      push_disp(16'd7, 16'hABCD, 1'b1, 3);
        send_cmd(3'd0, 6, 40'h31ABCD); wait_done();

        // preload R1, R2, R5, R6
        push_wr(5'd1, 16'h8000);      push_disp(16'd1, 16'h8000, 1'b1, 3);
        send_cmd(3'd0, 6, 40'h018000); wait_done();
        push_wr(5'd2, 16'h0001);      push_disp(16'd2, 16'h0001, 1'b1, 3);
        send_cmd(3'd0, 6, 40'h100001); wait_done();
        push_wr(5'd5, 16'h5555);      push_disp(16'd5, 16'h5555, 1'b1, 3);
        send_cmd(3'd0, 6, 40'h215555); wait_done();
        push_wr(5'd6, 16'h6666);      push_disp(16'd6, 16'h6666, 1'b1, 3);
        send_cmd(3'd0, 6, 40'h306666); wait_done();

        // cmd7 A=1 W=3 S=4: 0x8000 >>> 4
        push_wr(5'd3, 16'hF800);      push_disp(16'd3, 16'hF800, 1'b1, 3);
        send_cmd(3'd7, 5, 40'h01114);  wait_done();
        // cmd5 A=1 B=2 W=4: -32768 < 1
        push_wr(5'd4, 16'h0001);      push_disp(16'd4, 16'h0001, 1'b1, 3);
        send_cmd(3'd5, 6, 40'h011020); wait_done();
        // cmd6 A=3 B=1 W=8
        push_wr(5'd8, 16'h7800);      push_disp(16'd8, 16'h7800, 1'b1, 3);
        send_cmd(3'd6, 6, 40'h110140); wait_done();
        // cmd4 A=5 B=6 W=5 D=1234: post-write value shown
        push_wr(5'd5, 16'h1234);      push_disp(16'h1234, 16'h6666, 1'b0, 3);
        send_cmd(3'd4, 10, 40'h2130211234); wait_done();
        // cmd7 boundary shifts S=15 and S=0
        push_wr(5'd9, 16'hFFFF);      push_disp(16'd9, 16'hFFFF, 1'b1, 3);
        send_cmd(3'd7, 5, 40'h0141F);  wait_done();
        push_wr(5'd10, 16'h0001);     push_disp(16'd10, 16'h0001, 1'b1, 3);
        send_cmd(3'd7, 5, 40'h10500);  wait_done();
        // cmd5 A=2 B=1 W=11: 1 < -32768 false
        push_wr(5'd11, 16'h0000);     push_disp(16'd11, 16'h0000, 1'b1, 3);
        send_cmd(3'd5, 6, 40'h100151); wait_done();
        // cmd0 with tok[3:1] set on the second address token: W=16
        push_wr(5'd16, 16'h0F0F);     push_disp(16'd16, 16'h0F0F, 1'b1, 3);
        send_cmd(3'd0, 6, 40'h8E0F0F); wait_done();
        // cmd1 A=8, cmd2 A=3 B=4
        push_disp(16'd8, 16'h7800, 1'b1, 1);
        send_cmd(3'd1, 2, 40'h40);     wait_done();
        push_disp(16'hF800, 16'h0001, 1'b0, 1);
        send_cmd(3'd2, 4, 40'h1120);   wait_done();
        // cmd3 A=W=31 D=BEEF
        push_wr(5'd31, 16'hBEEF);     push_disp(16'd31, 16'hBEEF, 1'b1, 3);
        send_cmd(3'd3, 8, 40'hF3F1BEEF); wait_done();

        // disp_end during SHOW must be ignored
        early_end = 1'b1;
        push_disp(16'h8000, 16'h0001, 1'b0, 1);
        send_cmd(3'd2, 4, 40'h0110);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (disp_start) break;
        end
        @(negedge clk);
        chk("early_end_ignored", {disp_start, busy}, 2'b11);
        wait_done();
        early_end = 1'b0;

        // cmd_valid/tok_valid held during WAIT_DISP
        disp_delay = 6;
        push_wr(5'd12, 16'h8001);     push_disp(16'd12, 16'h8001, 1'b1, 3);
        send_cmd(3'd6, 6, 40'h011060);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (disp_start) break;
        end
        cmd = 3'd1;
        tok = 4'h5;
        cmd_valid = 1'b1;
        tok_valid = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (disp_end) begin
                cmd_valid = 1'b0;
                tok_valid = 1'b0;
                break;
            end
            chk("hold_wait_disp", {tok_ready, cmd_ready, disp_start}, 3'b001);
        end
        wait_done();
        chk("no_relatch", busy, 0);
        disp_delay = 3;

        // idle gap in COLLECT
        rise0 = n_rise;
`ifdef SEQ_TIMEOUT_EN
        send_cmd(3'd1, 1, 40'h2);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (err) break;
        end
        chk("err_pulse", err, 1);
        chk("err_latency", cyc - last_tok, 9);
        chk("tmo_idle", busy, 0);
        @(negedge clk);
        chk("err_one_cycle", err, 0);
        repeat (4) @(negedge clk);
        chk("tmo_no_disp", n_rise - rise0, 0);
        @(posedge clk);
        #1;
`else
        push_disp(16'd4, 16'h0001, 1'b1, 1);
        send_cmd(3'd1, 1, 40'h2);
        repeat (12) @(negedge clk);
        chk("no_timeout", {busy, tok_ready, err}, 3'b110);
        chk("no_timeout_disp", n_rise - rise0, 0);
        @(posedge clk);
        #1;
        send_tok(1, 40'h0);
        wait_done();
        chk("err_never", n_err, 0);
`endif

        // asynchronous reset mid-collect
        send_cmd(3'd0, 3, 40'h31A);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_ctl", {busy, tok_ready, rf_we, disp_start, done, err, disp_hi_is_addr,
                         rf_raddr1, rf_raddr2, rf_waddr}, 0);
        chk("arst_data", {rf_wdata, disp_hi}, 0);
        chk("arst_lo", disp_lo, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("arst_idle", {cmd_ready, busy}, 2'b10);
        push_disp(16'd16, 16'h0F0F, 1'b1, 1);
        send_cmd(3'd1, 2, 40'h80);
        wait_done();

        repeat (5) @(posedge clk);
        chk("wr_queue_drained", exp_wr.size(), 0);
        chk("disp_queue_drained", exp_disp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
